// File: rtl/lc3_dcache_pkg.sv
// lc3_cache_pkg
// Shared types and constants for the LC-3 data cache.
//   cache_state_e : controller FSM states (also exposed on the state probe)
//   TAG_W/IDX_W/OFF_W : address split {tag, index, offset}
//   line_t        : one cache line, tag plus four 16-bit words
//   line_word()   : pick one word out of a packed line
package lc3_cache_pkg;

  localparam int WORD_W = 16;
  localparam int TAG_W  = 10;
  localparam int IDX_W  = 4;
  localparam int OFF_W  = 2;
  localparam int LINE_W = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    RD_REQ = 3'd2,
    FILL   = 3'd3,
    WR_REQ = 3'd4,
    DONE   = 3'd5
  } cache_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  // Word k of a line lives in data[16k+15:16k].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] data,
                                                  input logic [OFF_W-1:0]  off);
    return data[{off, 4'b0000} +: WORD_W];
  endfunction

endpackage

// File: rtl/lc3_dcache_if.sv
// lc3_dcache_if
// Memory-side bus of the data cache: line-read request/accept, read beats,
// and single-word write request/accept.
//   master : cache side (drives rrqst, rdacpt, wrqst, maddr, mdout)
//   slave  : memory side (drives rrdy, rdrdy, mdin, wacpt)
interface lc3_dcache_if #(
  parameter int W = 16
) ();

  logic         rrqst;
  logic         rrdy;
  logic         rdrdy;
  logic         rdacpt;
  logic [W-1:0] mdin;
  logic         wrqst;
  logic         wacpt;
  logic [W-1:0] maddr;
  logic [W-1:0] mdout;

  modport master (
    output rrqst, rdacpt, wrqst, maddr, mdout,
    input  rrdy, rdrdy, mdin, wacpt
  );

  modport slave (
    input  rrqst, rdacpt, wrqst, maddr, mdout,
    output rrdy, rdrdy, mdin, wacpt
  );

endinterface

// File: rtl/lc3_dcache_array.sv
// lc3_dcache_array
// Line storage for the direct-mapped cache plus the per-line valid bits.
//   clock, reset_n : clock and async active-low reset (clears valid bits only)
//   rd_idx -> rd_line, rd_valid : combinational read port
//   line_we/line_idx/line_wdata : whole-line write (refill), sets valid
//   word_we/word_idx/word_off/word_data : single-word write (store hit)
//   validarr : valid bits, one per line
module lc3_dcache_array
  import lc3_cache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output line_t             rd_line,
  output logic              rd_valid,
  input  logic              line_we,
  input  logic [IDX_W-1:0]  line_idx,
  input  line_t             line_wdata,
  input  logic              word_we,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [WORD_W-1:0] word_data,
  output logic [LINES-1:0]  validarr
);

  line_t lines [LINES];

  // Tag/data storage is deliberately not reset; the valid bits guard it.
  always_ff @(posedge clock) begin
    if (line_we) begin
      lines[line_idx] <= line_wdata;
    end else if (word_we) begin
      lines[word_idx].data[{word_off, 4'b0000} +: WORD_W] <= word_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      validarr <= '0;
    end else if (line_we) begin
      validarr[line_idx] <= 1'b1;
    end
  end

  assign rd_line  = lines[rd_idx];
  assign rd_valid = validarr[rd_idx];

endmodule

// File: rtl/lc3_dcache.sv
// lc3_dcache
// Direct-mapped, write-through, no-write-allocate data cache for the LC-3
// MemAccess stage. One access in flight; loads that miss refill a 4-word line.
//   clock, reset_n         : clock and async active-low reset
//   dmac, rd, addr, din    : access request (sampled only in IDLE)
//   dout, complete         : load data and one-cycle done pulse
//   miss, state, validarr  : probe outputs
//   mem (master)           : memory bus (rrqst/rrdy, rdrdy/rdacpt/mdin,
//                            wrqst/wacpt, maddr, mdout)
module lc3_dcache
  import lc3_cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dmac,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              complete,
  output logic              miss,
  output logic [2:0]        state,
  output logic [LINES-1:0]  validarr,
  lc3_dcache_if.master      mem
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  cache_state_e      state_q, state_d;
  logic              req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_din;
  logic              miss_q;
  logic [ADDR_W-1:0] dout_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [ADDR_W-1:0] mdout_q;
  logic [OFF_W-1:0]  count;
  logic [LINE_W-1:0] beat_buf;
  logic [LINE_W-1:0] fill_data;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;

  line_t             rd_line;
  line_t             fill_line;
  logic              rd_valid;
  logic              hit;
  logic              line_we;
  logic              word_we;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[OFF_W+IDX_W +: TAG_W];

  assign hit = rd_valid && (rd_line.tag == req_tag);

  // The last beat goes straight from mdin into the line, so the buffer only
  // ever holds the earlier beats when the line is written.
  always_comb begin
    fill_data = beat_buf;
    fill_data[{count, 4'b0000} +: WORD_W] = mem.mdin;
  end

  assign fill_line = '{tag: req_tag, data: fill_data};

  lc3_dcache_array #(
    .LINES(LINES)
  ) u_array (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_idx    (req_idx),
    .rd_line   (rd_line),
    .rd_valid  (rd_valid),
    .line_we   (line_we),
    .line_idx  (req_idx),
    .line_wdata(fill_line),
    .word_we   (word_we),
    .word_idx  (req_idx),
    .word_off  (req_off),
    .word_data (req_din),
    .validarr  (validarr)
  );

  // Next-state logic; array write strobes fire on the edge leaving FILL or
  // WR_REQ. A store miss writes memory only and never touches the array.
  always_comb begin
    state_d = state_q;
    line_we = 1'b0;
    word_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmac) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (!req_rd)  state_d = WR_REQ;
        else if (hit) state_d = DONE;
        else          state_d = RD_REQ;
      end
      RD_REQ: begin
        if (mem.rrdy) state_d = FILL;
      end
      FILL: begin
        if (mem.rdrdy && (count == LAST_BEAT)) begin
          line_we = 1'b1;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        if (mem.wacpt) begin
          word_we = !miss_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, miss flag, memory address/data and refill beat capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_rd   <= 1'b0;
      req_addr <= '0;
      req_din  <= '0;
      miss_q   <= 1'b0;
      dout_q   <= '0;
      maddr_q  <= '0;
      mdout_q  <= '0;
      count    <= '0;
      beat_buf <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (dmac) begin
            req_rd   <= rd;
            req_addr <= addr;
            req_din  <= din;
          end
        end
        LOOKUP: begin
          miss_q <= !hit;
          if (req_rd) begin
            maddr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
            if (hit) dout_q <= line_word(rd_line.data, req_off);
          end else begin
            maddr_q <= req_addr;
            mdout_q <= req_din;
          end
        end
        FILL: begin
          if (mem.rdrdy) begin
            beat_buf[{count, 4'b0000} +: WORD_W] <= mem.mdin;
            count <= count + 1'b1;
            if (count == LAST_BEAT) dout_q <= line_word(fill_data, req_off);
          end
        end
        DONE: begin
          miss_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dout       = dout_q;
  assign complete   = (state_q == DONE);
  assign miss       = miss_q;
  assign state      = state_q;
  assign mem.rrqst  = (state_q == RD_REQ);
  assign mem.rdacpt = (state_q == FILL) && mem.rdrdy;
  assign mem.wrqst  = (state_q == WR_REQ);
  assign mem.maddr  = maddr_q;
  assign mem.mdout  = mdout_q;

endmodule

// File: tb/tb_lc3_dcache.sv
// tb_lc3_dcache
// Directed bench for lc3_dcache. Each access pushes its expected completion
// (dout, miss, validarr) into a queue; a monitor pops and compares whenever
// complete is high. The main thread plays the memory side and checks the
// request/handshake timing around each access.
module tb_lc3_dcache;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        dmac     = 1'b0;
  logic        rd       = 1'b0;
  logic [15:0] addr     = '0;
  logic [15:0] din      = '0;
  logic [15:0] dout;
  logic        complete;
  logic        miss;
  logic [2:0]  state;
  logic [15:0] validarr;

  lc3_dcache_if mem_if ();

  lc3_dcache dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dmac    (dmac),
    .rd      (rd),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .complete(complete),
    .miss    (miss),
    .state   (state),
    .validarr(validarr),
    .mem     (mem_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_load;
    logic [15:0] dout;
    logic        miss;
    logic [15:0] valid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every complete pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && complete) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_complete", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_load) checkOutput("sb_dout", dout, e.dout);
        checkOutput("sb_miss", miss, e.miss);
        checkOutput("sb_validarr", validarr, e.valid);
      end
    end
  end

  task automatic resetChecks();
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_dout", dout, 16'h0);
    checkOutput("rst_complete", complete, 1'b0);
    checkOutput("rst_miss", miss, 1'b0);
    checkOutput("rst_validarr", validarr, 16'h0);
    checkOutput("rst_rrqst", mem_if.rrqst, 1'b0);
    checkOutput("rst_rdacpt", mem_if.rdacpt, 1'b0);
    checkOutput("rst_wrqst", mem_if.wrqst, 1'b0);
    checkOutput("rst_maddr", mem_if.maddr, 16'h0);
    checkOutput("rst_mdout", mem_if.mdout, 16'h0);
  endtask

  // Called at a negedge with the cache idle; returns in the LOOKUP cycle.
  task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [15:0] d,
                               input logic e_miss, input logic [15:0] e_dout,
                               input logic [15:0] e_valid);
    exp_t e;
    e.is_load = r;
    e.dout    = e_dout;
    e.miss    = e_miss;
    e.valid   = e_valid;
    sb.push_back(e);
    dmac = 1'b1;
    rd   = r;
    addr = a;
    din  = d;
    @(negedge clock);
    dmac = 1'b0;
    checkOutput("lookup_state", state, 3'd1);
  endtask

  task automatic loadHit(input logic [15:0] a, input logic [15:0] e_dout,
                         input logic [15:0] e_valid);
    applyStimulus(1'b1, a, 16'h0, 1'b0, e_dout, e_valid);
    @(negedge clock);
    checkOutput("hit_complete_timing", complete, 1'b1);
    checkOutput("hit_no_rrqst", mem_if.rrqst, 1'b0);
    @(negedge clock);
  endtask

  // Memory side of a load miss; abort_after < 4 resets the cache mid-fill.
  task automatic serviceLoad(input logic [15:0] exp_maddr, input int acc_delay,
                             input logic [15:0] base, input int gap, input int abort_after);
    @(negedge clock);
    checkOutput("rrqst_rise", mem_if.rrqst, 1'b1);
    checkOutput("rd_maddr", mem_if.maddr, exp_maddr);
    checkOutput("miss_flag", miss, 1'b1);
    for (int i = 0; i < acc_delay; i++) begin
      mem_if.rdrdy = 1'b1;
      mem_if.mdin  = 16'hDEAD;
      #1;
      checkOutput("rdacpt_outside_fill", mem_if.rdacpt, 1'b0);
      @(negedge clock);
      mem_if.rdrdy = 1'b0;
      checkOutput("rrqst_hold", mem_if.rrqst, 1'b1);
      checkOutput("rd_maddr_hold", mem_if.maddr, exp_maddr);
    end
    mem_if.rrdy = 1'b1;
    @(negedge clock);
    mem_if.rrdy = 1'b0;
    checkOutput("fill_state", state, 3'd3);
    checkOutput("rrqst_drop", mem_if.rrqst, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == abort_after) begin
        reset_n = 1'b0;
        #1;
        resetChecks();
        void'(sb.pop_back());
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        return;
      end
      repeat (gap) @(negedge clock);
      mem_if.rdrdy = 1'b1;
      mem_if.mdin  = 16'(base + 16'(k));
      #1;
      checkOutput("rdacpt_beat", mem_if.rdacpt, 1'b1);
      @(negedge clock);
      mem_if.rdrdy = 1'b0;
    end
    checkOutput("load_complete_timing", complete, 1'b1);
    @(negedge clock);
  endtask

  task automatic serviceStore(input logic [15:0] a, input logic [15:0] d, input int hold);
    @(negedge clock);
    for (int i = 0; i < hold; i++) begin
      checkOutput("wrqst_hold", mem_if.wrqst, 1'b1);
      checkOutput("wr_maddr", mem_if.maddr, a);
      checkOutput("wr_mdout", mem_if.mdout, d);
      @(negedge clock);
    end
    checkOutput("wrqst_at_accept", mem_if.wrqst, 1'b1);
    checkOutput("wr_maddr_accept", mem_if.maddr, a);
    mem_if.wacpt = 1'b1;
    @(negedge clock);
    mem_if.wacpt = 1'b0;
    checkOutput("store_complete_timing", complete, 1'b1);
    checkOutput("wrqst_drop", mem_if.wrqst, 1'b0);
    @(negedge clock);
  endtask

  initial begin
    mem_if.rrdy  = 1'b0;
    mem_if.rdrdy = 1'b0;
    mem_if.mdin  = '0;
    mem_if.wacpt = 1'b0;
    repeat (2) @(negedge clock);
    resetChecks();
    reset_n = 1'b1;
    @(negedge clock);

    // rdrdy while idle must not be accepted
    mem_if.rdrdy = 1'b1;
    #1;
    checkOutput("rdacpt_idle", mem_if.rdacpt, 1'b0);
    mem_if.rdrdy = 1'b0;
    @(negedge clock);

    $display("[TB] cold load miss 0x3012");
    applyStimulus(1'b1, 16'h3012, 16'h0, 1'b1, 16'h00A2, 16'h0010);
    serviceLoad(16'h3010, 2, 16'h00A0, 1, 4);

    $display("[TB] load hit 0x3011");
    loadHit(16'h3011, 16'h00A1, 16'h0010);

    $display("[TB] store hit 0x3013 with slow accept");
    applyStimulus(1'b0, 16'h3013, 16'h5555, 1'b0, 16'h0, 16'h0010);
    serviceStore(16'h3013, 16'h5555, 3);
    loadHit(16'h3013, 16'h5555, 16'h0010);

    $display("[TB] conflict miss 0x7010, immediate accept");
    applyStimulus(1'b1, 16'h7010, 16'h0, 1'b1, 16'h00B0, 16'h0010);
    serviceLoad(16'h7010, 0, 16'h00B0, 0, 4);
    applyStimulus(1'b1, 16'h3012, 16'h0, 1'b1, 16'h00C2, 16'h0010);
    serviceLoad(16'h3010, 1, 16'h00C0, 0, 4);

    $display("[TB] store miss 0x4000, no allocate");
    applyStimulus(1'b0, 16'h4000, 16'h1234, 1'b1, 16'h0, 16'h0010);
    serviceStore(16'h4000, 16'h1234, 0);
    checkOutput("no_allocate_valid0", validarr[0], 1'b0);
    applyStimulus(1'b1, 16'h4000, 16'h0, 1'b1, 16'h00D0, 16'h0011);
    serviceLoad(16'h4000, 0, 16'h00D0, 2, 4);

    $display("[TB] reset during refill of 0x5024");
    applyStimulus(1'b1, 16'h5024, 16'h0, 1'b1, 16'h0, 16'h0);
    serviceLoad(16'h5024, 0, 16'h00F0, 1, 2);
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, 16'h3012, 16'h0, 1'b1, 16'h00E2, 16'h0010);
    serviceLoad(16'h3010, 0, 16'h00E0, 0, 4);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
